cacheline_adapter: RTL

Bridges the data cache's 256-bit line-granular memory port (dfp_*) to the 64-bit burst memory interface (bmem_*). It sits directly downstream of the data cache: one line fill becomes a 4-beat read burst collected into a 256-bit line, and one dirty-line writeback becomes a 4-beat write burst. Each completed transfer is acknowledged with a single-cycle dfp_resp.

---
 rtl/cacheline_adapter_if.sv | 41 ++++
 rtl/cacheline_adapter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cacheline_adapter_if.sv
// Bundle of the cache-side line port (dfp_*) and the memory-side burst port
// (bmem_*). The adapter uses the slave view; the cache/memory environment
// uses the master view.
interface cacheline_adapter_if #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64
) ();

  // Cache-side line port
  logic [31:0]           dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [LINE_BITS-1:0]  dfp_wdata;
  logic [LINE_BITS-1:0]  dfp_rdata;
  logic                  dfp_resp;

  // Memory-side burst port
  logic [31:0]           bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BURST_BITS-1:0] bmem_wdata;
  logic                  bmem_ready;
  logic [31:0]           bmem_raddr;
  logic [BURST_BITS-1:0] bmem_rdata;
  logic                  bmem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

endinterface

// File: rtl/cacheline_adapter.sv
// Converts one 256-bit line fill into a 4-beat 64-bit read burst and one
// dirty-line writeback into a 4-beat write burst. Every completed transfer
// is acknowledged with a single-cycle dfp_resp. All outputs are decoded from
// registered state (Moore), so nothing on bmem_* depends combinationally on
// the cache-side inputs.
module cacheline_adapter #(
  parameter int LINE_BITS  = 256,
  parameter int BURST_BITS = 64
) (
  input logic                clk,
  input logic                rst,
  cacheline_adapter_if.slave bus
);

  localparam int BEATS       = LINE_BITS / BURST_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int CNT_W       = $clog2(BEATS);

  localparam logic [31:0]      OFFSET_MASK = 32'((1 << OFFSET_BITS) - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RREQ,
    RWAIT,
    RESP
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [LINE_BITS-1:0] line, line_nx;
  logic [31:0]          addr, addr_nx;

  logic                 beat_hit;

  // A returning beat counts only if it is tagged with our burst address.
  assign beat_hit = bus.bmem_rvalid && (bus.bmem_raddr == addr);

  // State and datapath registers; the line buffer is cleared on reset so a
  // partially collected fill never leaks out after a reset.
  // NOTE: the line buffer is a plain register, not a RAM, so it takes the async reset like the rest of the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      line  <= '0;
      addr  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state <= state_nx;
      cnt   <= cnt_nx;
      line  <= line_nx;
      addr  <= addr_nx;
    end
  end

  // Next-state and datapath update; write requests win over reads.
  always_comb begin
    // NOTE: every target gets a hold default first, so no path can infer a latch.
    state_nx = state;
    cnt_nx   = cnt;
    line_nx  = line;
    addr_nx  = addr;

    unique case (state)
      IDLE: begin
        if (bus.dfp_write && bus.bmem_ready) begin
          line_nx  = bus.dfp_wdata;
          addr_nx  = bus.dfp_addr & ~OFFSET_MASK;
          cnt_nx   = '0;
          state_nx = WRITE;
        end else if (bus.dfp_read && bus.bmem_ready) begin
          addr_nx  = bus.dfp_addr & ~OFFSET_MASK;
          cnt_nx   = '0;
          state_nx = RREQ;
        end
      end

      WRITE: begin
        // Memory takes one beat per cycle once the burst has started.
        if (cnt == LAST_BEAT) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      RREQ: begin
        state_nx = RWAIT;
      end

      RWAIT: begin
        if (beat_hit) begin
          line_nx[BURST_BITS*cnt +: BURST_BITS] = bus.bmem_rdata;
          if (cnt == LAST_BEAT) begin
            state_nx = RESP;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end

      RESP: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Moore output decode.
  assign bus.dfp_resp   = (state == RESP);
  assign bus.dfp_rdata  = line;
  assign bus.bmem_read  = (state == RREQ);
  assign bus.bmem_write = (state == WRITE);
  assign bus.bmem_wdata = (state == WRITE) ? line[BURST_BITS*cnt +: BURST_BITS]
                                           : '0;
  assign bus.bmem_addr  = (state == WRITE || state == RREQ || state == RWAIT)
                          ? addr : 32'h0;

endmodule
